// File: rtl/reorder_buffer_pkg.sv
// Shared widths and depths for the reorder buffer and the blocks that talk to it.
package reorder_buffer_pkg;

   localparam int InstBus     = 32;
   localparam int AddrBus     = 32;
   localparam int RegBus      = 32;
   localparam int RegAddrBus  = 5;

   // Entry count, tag width (RobTagBus-1:0) and occupancy width (0..RobDepth inclusive).
   localparam int RobDepth    = 16;
   localparam int RobTagBus   = 4;
   localparam int RobCountBus = RobTagBus + 1;

endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates per dispatched instruction, captures CDB results,
// answers operand queries and retires in program order, flushing on a head mispredict.
module reorder_buffer
   import reorder_buffer_pkg::*;
#(
   parameter int DEPTH = RobDepth,
   parameter int TAG_W = RobTagBus
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  rdy_in,

   input  logic                  dispatch_rob_rdy,
   input  logic [InstBus-1:0]    disp_inst,
   input  logic [AddrBus-1:0]    disp_npc,
   input  logic [RegAddrBus-1:0] disp_rd,
   input  logic                  disp_rd_in_need,
   output logic [TAG_W-1:0]      alloc_tag,
   output logic                  rob_full,
   output logic                  rob_overflow,

   input  logic                  cdb_valid,
   input  logic [TAG_W-1:0]      cdb_tag,
   input  logic [RegBus-1:0]     cdb_value,
   input  logic                  cdb_jump,
   input  logic [AddrBus-1:0]    cdb_target,

   input  logic [TAG_W-1:0]      query_tag1,
   input  logic [TAG_W-1:0]      query_tag2,
   output logic                  query_ready1,
   output logic                  query_ready2,
   output logic [RegBus-1:0]     query_value1,
   output logic [RegBus-1:0]     query_value2,

   output logic                  commit_valid,
   output logic [RegAddrBus-1:0] commit_rd,
   output logic                  commit_rd_in_need,
   output logic [RegBus-1:0]     commit_value,
   output logic [TAG_W-1:0]      commit_tag,
   output logic                  flush_out,
   output logic [AddrBus-1:0]    flush_pc
);

   localparam logic [TAG_W:0] CntFull   = (TAG_W+1)'(DEPTH);
   localparam logic [TAG_W:0] CntAlmost = (TAG_W+1)'(DEPTH - 1);

   logic [DEPTH-1:0]      busy;
   logic [DEPTH-1:0]      ready;
   logic [DEPTH-1:0]      jump;
   logic [RegAddrBus-1:0] rd         [DEPTH];
   logic                  rd_in_need [DEPTH];
   logic [RegBus-1:0]     val        [DEPTH];
   logic [AddrBus-1:0]    target     [DEPTH];
   logic [AddrBus-1:0]    npc        [DEPTH];

   logic [TAG_W-1:0]      head;
   logic [TAG_W-1:0]      tail;
   logic [TAG_W:0]        count;

   logic do_alloc;
   logic do_wb;
   logic do_commit;
   logic do_flush;
   logic bypass1;
   logic bypass2;

   assign do_alloc  = rdy_in && dispatch_rob_rdy && (count != CntFull);
   assign do_wb     = rdy_in && cdb_valid && busy[cdb_tag];
   assign do_commit = rdy_in && busy[head] && ready[head];
   assign do_flush  = do_commit && jump[head];

   assign alloc_tag = tail;
   // One slot stays in reserve for the instruction already sitting in the dispatch register.
   assign rob_full  = (count >= CntAlmost);

   assign bypass1      = cdb_valid && (cdb_tag == query_tag1);
   assign bypass2      = cdb_valid && (cdb_tag == query_tag2);
   assign query_ready1 = bypass1 || (busy[query_tag1] && ready[query_tag1]);
   assign query_ready2 = bypass2 || (busy[query_tag2] && ready[query_tag2]);
   assign query_value1 = bypass1 ? cdb_value : val[query_tag1];
   assign query_value2 = bypass2 ? cdb_value : val[query_tag2];

   // The instruction word and PC are kept for debug visibility only.
   logic unused_sink;
   assign unused_sink = ^{disp_inst, npc[head]};

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         busy  <= '0;
         ready <= '0;
         jump  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            rd[i]         <= '0;
            rd_in_need[i] <= 1'b0;
            val[i]        <= '0;
            target[i]     <= '0;
            npc[i]        <= '0;
         end
         head              <= '0;
         tail              <= '0;
         count             <= '0;
         rob_overflow      <= 1'b0;
         commit_valid      <= 1'b0;
         commit_rd         <= '0;
         commit_rd_in_need <= 1'b0;
         commit_value      <= '0;
         commit_tag        <= '0;
         flush_out         <= 1'b0;
         flush_pc          <= '0;
      end else begin
         commit_valid <= 1'b0;
         flush_out    <= 1'b0;
         if (rdy_in) begin
            if (dispatch_rob_rdy && (count == CntFull)) begin
               rob_overflow <= 1'b1;
            end
            if (do_commit) begin
               commit_valid      <= 1'b1;
               commit_rd         <= rd[head];
               commit_rd_in_need <= rd_in_need[head];
               commit_value      <= val[head];
               commit_tag        <= head;
            end
            if (do_flush) begin
               // Everything younger than the mispredicted jump is squashed, including this cycle's traffic.
               flush_out <= 1'b1;
               flush_pc  <= target[head];
               busy      <= '0;
               head      <= '0;
               tail      <= '0;
               count     <= '0;
            end else begin
               if (do_wb) begin
                  ready[cdb_tag]  <= 1'b1;
                  val[cdb_tag]    <= cdb_value;
                  jump[cdb_tag]   <= cdb_jump;
                  target[cdb_tag] <= cdb_target;
               end
               if (do_alloc) begin
                  busy[tail]       <= 1'b1;
                  ready[tail]      <= 1'b0;
                  jump[tail]       <= 1'b0;
                  rd[tail]         <= disp_rd;
                  rd_in_need[tail] <= disp_rd_in_need;
                  npc[tail]        <= disp_npc;
                  tail             <= tail + 1'b1;
               end
               if (do_commit) begin
                  busy[head] <= 1'b0;
                  head       <= head + 1'b1;
               end
               case ({do_alloc, do_commit})
                  2'b10:   count <= count + 1'b1;
                  2'b01:   count <= count - 1'b1;
                  default: count <= count;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: stimulus pushes expected retirements into a queue,
// an independent monitor pops and compares every commit pulse.
module tb_reorder_buffer;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b0;
   logic        rdy_in = 1'b1;
   logic        dispatch_rob_rdy = 1'b0;
   logic [31:0] disp_inst = '0;
   logic [31:0] disp_npc = '0;
   logic [4:0]  disp_rd = '0;
   logic        disp_rd_in_need = 1'b0;
   logic [3:0]  alloc_tag;
   logic        rob_full;
   logic        rob_overflow;
   logic        cdb_valid = 1'b0;
   logic [3:0]  cdb_tag = '0;
   logic [31:0] cdb_value = '0;
   logic        cdb_jump = 1'b0;
   logic [31:0] cdb_target = '0;
   logic [3:0]  query_tag1 = '0;
   logic [3:0]  query_tag2 = '0;
   logic        query_ready1;
   logic        query_ready2;
   logic [31:0] query_value1;
   logic [31:0] query_value2;
   logic        commit_valid;
   logic [4:0]  commit_rd;
   logic        commit_rd_in_need;
   logic [31:0] commit_value;
   logic [3:0]  commit_tag;
   logic        flush_out;
   logic [31:0] flush_pc;

   reorder_buffer dut (
      .clk_in           (clk_in),
      .rst_in           (rst_in),
      .rdy_in           (rdy_in),
      .dispatch_rob_rdy (dispatch_rob_rdy),
      .disp_inst        (disp_inst),
      .disp_npc         (disp_npc),
      .disp_rd          (disp_rd),
      .disp_rd_in_need  (disp_rd_in_need),
      .alloc_tag        (alloc_tag),
      .rob_full         (rob_full),
      .rob_overflow     (rob_overflow),
      .cdb_valid        (cdb_valid),
      .cdb_tag          (cdb_tag),
      .cdb_value        (cdb_value),
      .cdb_jump         (cdb_jump),
      .cdb_target       (cdb_target),
      .query_tag1       (query_tag1),
      .query_tag2       (query_tag2),
      .query_ready1     (query_ready1),
      .query_ready2     (query_ready2),
      .query_value1     (query_value1),
      .query_value2     (query_value2),
      .commit_valid     (commit_valid),
      .commit_rd        (commit_rd),
      .commit_rd_in_need(commit_rd_in_need),
      .commit_value     (commit_value),
      .commit_tag       (commit_tag),
      .flush_out        (flush_out),
      .flush_pc         (flush_pc)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [3:0]  tag;
      logic [4:0]  rd;
      logic        need;
      logic        jump;
      logic [31:0] pc;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   logic [31:0] exp_val [16];
   int          n_checks = 0;
   int          n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk_in);
      #1;
   endtask

   task automatic dispatch(input logic [4:0] rd, input logic need, input logic jmp,
                           input logic [31:0] pc, input logic [3:0] exp_tag, input bit push);
      dispatch_rob_rdy = 1'b1;
      disp_rd          = rd;
      disp_rd_in_need  = need;
      disp_inst        = 32'h13 + 32'(rd);
      disp_npc         = 32'h1000 + 32'(rd) * 4;
      #1;
      check("alloc_tag", 32'(alloc_tag), 32'(exp_tag));
      if (push) sb.push_back('{tag: exp_tag, rd: rd, need: need, jump: jmp, pc: pc});
      tick();
      dispatch_rob_rdy = 1'b0;
   endtask

   task automatic cdb(input logic [3:0] tag, input logic [31:0] v, input logic jmp, input logic [31:0] tgt);
      cdb_valid    = 1'b1;
      cdb_tag      = tag;
      cdb_value    = v;
      cdb_jump     = jmp;
      cdb_target   = tgt;
      exp_val[tag] = v;
   endtask

   // Monitor: every commit pulse must match the oldest outstanding expectation.
   always @(negedge clk_in) begin
      if (rst_in) begin
         if (commit_valid) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_commit: got tag %0d, expected no commit", commit_tag);
            end else begin
               mon_e = sb.pop_front();
               check("commit_tag", 32'(commit_tag), 32'(mon_e.tag));
               check("commit_rd", 32'(commit_rd), 32'(mon_e.rd));
               check("commit_rd_in_need", 32'(commit_rd_in_need), 32'(mon_e.need));
               check("commit_value", commit_value, exp_val[mon_e.tag]);
               check("commit_flush", 32'(flush_out), 32'(mon_e.jump));
               if (mon_e.jump) begin
                  check("flush_pc", flush_pc, mon_e.pc);
                  sb.delete();
               end
            end
         end else if (flush_out) begin
            n_checks++;
            n_errors++;
            $display("FAIL flush_without_commit: got flush_out 1, expected 0");
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got time limit reached, expected bench completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 16; i++) exp_val[i] = '0;
      #3;
      check("rst_commit_valid", 32'(commit_valid), 32'd0);
      check("rst_flush_out", 32'(flush_out), 32'd0);
      check("rst_flush_pc", flush_pc, 32'd0);
      check("rst_overflow", 32'(rob_overflow), 32'd0);
      check("rst_full", 32'(rob_full), 32'd0);
      check("rst_alloc_tag", 32'(alloc_tag), 32'd0);
      check("rst_query_ready", 32'(query_ready1), 32'd0);
      tick();
      rst_in = 1'b1;
      tick();

      // Three dispatches, out-of-order writeback, in-order retirement.
      for (int i = 0; i < 3; i++) dispatch(5'(i + 1), 1'b1, 1'b0, 32'd0, 4'(i), 1'b1);
      check("alloc_tag_after3", 32'(alloc_tag), 32'd3);
      check("full_after3", 32'(rob_full), 32'd0);
      query_tag1 = 4'd0;
      #1;
      check("query_not_ready", 32'(query_ready1), 32'd0);
      cdb(4'd1, 32'h11, 1'b0, 32'd0);
      tick();
      cdb(4'd0, 32'h22, 1'b0, 32'd0);
      query_tag2 = 4'd1;
      #1;
      check("query2_ready_stored", 32'(query_ready2), 32'd1);
      check("query2_value_stored", query_value2, 32'h11);
      tick();
      cdb_valid = 1'b0;
      tick();
      check("first_commit_valid", 32'(commit_valid), 32'd1);
      check("first_commit_tag", 32'(commit_tag), 32'd0);
      tick();
      check("second_commit_valid", 32'(commit_valid), 32'd1);
      check("second_commit_tag", 32'(commit_tag), 32'd1);

      // Same-cycle CDB bypass on the query port.
      query_tag1 = 4'd2;
      cdb(4'd2, 32'hAB, 1'b0, 32'd0);
      #1;
      check("bypass_ready", 32'(query_ready1), 32'd1);
      check("bypass_value", query_value1, 32'hAB);
      tick();
      cdb_valid = 1'b0;
      repeat (3) tick();
      check("drain_after_bypass", 32'(sb.size()), 32'd0);

      // Fill from head=3, overflow, then sixteen back-to-back commits wrapping the head.
      for (int i = 0; i < 15; i++) begin
         if (i == 14) check("full_at_14", 32'(rob_full), 32'd0);
         dispatch(5'(i + 1), 1'b1, 1'b0, 32'd0, 4'((3 + i) % 16), 1'b1);
      end
      check("full_at_15", 32'(rob_full), 32'd1);
      check("no_overflow_at_15", 32'(rob_overflow), 32'd0);
      dispatch(5'd20, 1'b1, 1'b0, 32'd0, 4'd2, 1'b1);
      check("full_at_16", 32'(rob_full), 32'd1);
      check("no_overflow_at_16", 32'(rob_overflow), 32'd0);
      dispatch(5'd21, 1'b1, 1'b0, 32'd0, 4'd3, 1'b0);
      check("overflow_set", 32'(rob_overflow), 32'd1);
      for (int i = 0; i < 16; i++) begin
         cdb(4'((3 + i) % 16), 32'h100 + 32'(i), 1'b0, 32'd0);
         tick();
      end
      cdb_valid = 1'b0;
      repeat (4) tick();
      check("drain_after_fill", 32'(sb.size()), 32'd0);
      check("tail_after_fill", 32'(alloc_tag), 32'd3);
      check("overflow_sticky", 32'(rob_overflow), 32'd1);
      check("not_full_after_drain", 32'(rob_full), 32'd0);

      // Global enable low freezes allocation and writeback.
      dispatch(5'd7, 1'b0, 1'b0, 32'd0, 4'd3, 1'b1);
      rdy_in           = 1'b0;
      dispatch_rob_rdy = 1'b1;
      disp_rd          = 5'd8;
      cdb(4'd3, 32'h55, 1'b0, 32'd0);
      tick();
      tick();
      dispatch_rob_rdy = 1'b0;
      cdb_valid        = 1'b0;
      query_tag1       = 4'd3;
      #1;
      check("frozen_alloc_tag", 32'(alloc_tag), 32'd4);
      check("frozen_no_writeback", 32'(query_ready1), 32'd0);
      check("frozen_no_commit", 32'(commit_valid), 32'd0);
      rdy_in = 1'b1;
      cdb(4'd3, 32'h56, 1'b0, 32'd0);
      tick();
      cdb_valid = 1'b0;
      repeat (3) tick();
      check("drain_after_freeze", 32'(sb.size()), 32'd0);

      // Mispredicted jump at head: flush, with a dispatch and a writeback in the commit cycle.
      dispatch(5'd9, 1'b1, 1'b1, 32'h100, 4'd4, 1'b1);
      dispatch(5'd10, 1'b1, 1'b0, 32'd0, 4'd5, 1'b1);
      cdb(4'd4, 32'h44, 1'b1, 32'h100);
      tick();
      dispatch_rob_rdy = 1'b1;
      disp_rd          = 5'd11;
      cdb(4'd5, 32'h99, 1'b0, 32'd0);
      tick();
      dispatch_rob_rdy = 1'b0;
      cdb_valid        = 1'b0;
      query_tag1       = 4'd5;
      #1;
      check("flush_pulse", 32'(flush_out), 32'd1);
      check("flush_target", flush_pc, 32'h100);
      check("flush_commit_valid", 32'(commit_valid), 32'd1);
      check("tail_after_flush", 32'(alloc_tag), 32'd0);
      check("flushed_entry_not_ready", 32'(query_ready1), 32'd0);
      tick();
      check("flush_one_cycle", 32'(flush_out), 32'd0);
      check("commit_one_cycle", 32'(commit_valid), 32'd0);
      cdb(4'd5, 32'h98, 1'b0, 32'd0);
      tick();
      cdb_valid = 1'b0;
      #1;
      check("wb_nonbusy_ignored", 32'(query_ready1), 32'd0);
      repeat (2) tick();
      check("drain_after_flush", 32'(sb.size()), 32'd0);

      // Occupancy restarted at zero: 14 entries leave room, the 15th asserts full.
      for (int i = 0; i < 14; i++) dispatch(5'(i + 1), 1'b1, 1'b0, 32'd0, 4'(i), 1'b0);
      check("count_zero_after_flush", 32'(rob_full), 32'd0);
      dispatch(5'd15, 1'b1, 1'b0, 32'd0, 4'd14, 1'b0);
      check("full_after_refill", 32'(rob_full), 32'd1);

      // Asynchronous reset between edges.
      rst_in = 1'b0;
      #1;
      check("async_rst_full", 32'(rob_full), 32'd0);
      check("async_rst_alloc_tag", 32'(alloc_tag), 32'd0);
      sb.delete();
      tick();
      rst_in = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) dispatch(5'(i + 1), 1'b1, 1'b0, 32'd0, 4'(i), 1'b1);
      cdb(4'd0, 32'h77, 1'b0, 32'd0);
      tick();
      cdb_valid = 1'b0;
      tick();
      check("pre_reset_commit", 32'(commit_valid), 32'd1);
      #1;
      rst_in = 1'b0;
      #1;
      check("rst_clears_commit_valid", 32'(commit_valid), 32'd0);
      check("rst_clears_commit_rd", 32'(commit_rd), 32'd0);
      check("rst_clears_commit_value", commit_value, 32'd0);
      check("rst_clears_tail", 32'(alloc_tag), 32'd0);
      sb.delete();
      tick();
      rst_in = 1'b1;
      dispatch(5'd3, 1'b1, 1'b0, 32'd0, 4'd0, 1'b0);
      check("tail_after_post_reset_dispatch", 32'(alloc_tag), 32'd1);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
